// File: rtl/bit_serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The master drives the operands and accepts the result. The slave is the adder.
interface bit_serial_adder_if #(
    parameter int unsigned NBITS = 8
);
    logic             in_val;
    logic             in_rdy;
    logic [NBITS-1:0] in_a;
    logic [NBITS-1:0] in_b;
    logic             out_val;
    logic             out_rdy;
    logic [NBITS-1:0] out_sum;
    logic             out_cout;

    modport master (
        output in_val, in_a, in_b, out_rdy,
        input  in_rdy, out_val, out_sum, out_cout
    );

    modport slave (
        input  in_val, in_a, in_b, out_rdy,
        output in_rdy, out_val, out_sum, out_cout
    );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial unsigned adder: two half adders plus a carry flop, one bit per cycle LSB-first.
// Operands are taken over a valid/ready handshake, and {cout, sum} is returned over a second one.
module bit_serial_adder #(
    parameter int unsigned NBITS = 8
) (
    input logic               clk,
    input logic               reset,
    bit_serial_adder_if.slave bus_io
);
    localparam int unsigned     CntW    = $clog2(NBITS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(NBITS - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    typedef struct packed {
        logic sum;
        logic cout;
    } ha_t;

    function automatic ha_t half_add(input logic x, input logic y);
        ha_t r;
        r.sum  = x ^ y;
        r.cout = x & y;
        return r;
    endfunction

    state_e           state_q;
    logic [NBITS-1:0] a_sr_q;
    logic [NBITS-1:0] b_sr_q;
    logic [NBITS-1:0] result_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;

    ha_t              ha1;
    ha_t              ha2;
    logic             carry_d;
    logic [NBITS-1:0] result_d;

    always_comb begin
        ha1      = half_add(a_sr_q[0], b_sr_q[0]);
        ha2      = half_add(ha1.sum, carry_q);
        carry_d  = ha1.cout | ha2.cout;
        // The new bit enters at the MSB, so after NBITS shifts bit 0 lands at the LSB.
        result_d            = result_q >> 1;
        result_d[NBITS-1]   = ha2.sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.in_val) begin
                        a_sr_q   <= bus_io.in_a;
                        b_sr_q   <= bus_io.in_b;
                        result_q <= '0;
                        carry_q  <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    result_q <= result_d;
                    carry_q  <= carry_d;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bus_io.out_rdy) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The reset state is idle, but the block must not advertise ready while held in reset.
    assign bus_io.in_rdy   = (state_q == StIdle) && !reset;
    assign bus_io.out_val  = (state_q == StDone);
    assign bus_io.out_sum  = result_q;
    assign bus_io.out_cout = carry_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed scenarios plus a randomized
// back-to-back stream checked against an arithmetic reference queue.
module tb_bit_serial_adder;
    localparam int unsigned NBITS = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    bit_serial_adder_if #(.NBITS(NBITS)) bus ();

    bit_serial_adder #(.NBITS(NBITS)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: the exact (NBITS+1)-bit unsigned sum.
    function automatic logic [NBITS:0] ref_add(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
        int unsigned s;
        s = int'(a) + int'(b);
        return s[NBITS:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation with out_rdy held high. Reports the cycle out_val was seen
    // (the accept cycle is 0) and in_rdy one cycle later.
    task automatic run_op(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                          output logic [NBITS-1:0] sum, output logic cout,
                          output int cyc, output logic rdy_after);
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_val = 1'b1;
        tick();
        bus.in_val = 1'b0;
        cyc = 1;
        while (bus.out_val !== 1'b1 && cyc < 64) begin
            tick();
            cyc++;
        end
        sum  = bus.out_sum;
        cout = bus.out_cout;
        tick();
        rdy_after = bus.in_rdy;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.in_val  = 1'b0;
        bus.in_a    = '0;
        bus.in_b    = '0;
        bus.out_rdy = 1'b1;
        #2;
        n_checks++;
        if (bus.in_rdy !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_rdy: got %b want 0", bus.in_rdy);
        end
        n_checks++;
        if (bus.out_val !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_val: got %b want 0", bus.out_val);
        end
        n_checks++;
        if ({bus.out_cout, bus.out_sum} !== 9'h000) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 000", {bus.out_cout, bus.out_sum});
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_rdy: got %b want 1", bus.in_rdy);
        end
    endtask

    task automatic test_basic();
        logic [NBITS-1:0] sum;
        logic             cout;
        logic             rdy;
        int               cyc;
        run_op(8'h0F, 8'h01, sum, cout, cyc, rdy);
        n_checks++;
        if (cyc !== 9) begin
            n_fail++; $display("FAIL basic_latency: got %0d want 9", cyc);
        end
        n_checks++;
        if ({cout, sum} !== ref_add(8'h0F, 8'h01)) begin
            n_fail++; $display("FAIL basic_sum: got %h want %h", {cout, sum}, ref_add(8'h0F, 8'h01));
        end
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++; $display("FAIL basic_rdy_again: got %b want 1", rdy);
        end
    endtask

    task automatic test_overflow();
        logic [NBITS-1:0] sum;
        logic             cout;
        logic             rdy;
        int               cyc;
        run_op(8'hFF, 8'h01, sum, cout, cyc, rdy);
        n_checks++;
        if ({cout, sum} !== 9'h100) begin
            n_fail++; $display("FAIL ripple_ff_01: got %h want 100", {cout, sum});
        end
        run_op(8'hFF, 8'hFF, sum, cout, cyc, rdy);
        n_checks++;
        if ({cout, sum} !== 9'h1FE) begin
            n_fail++; $display("FAIL overflow_ff_ff: got %h want 1fe", {cout, sum});
        end
        n_checks++;
        if (cyc !== 9) begin
            n_fail++; $display("FAIL overflow_latency: got %0d want 9", cyc);
        end
    endtask

    task automatic test_backpressure();
        logic [NBITS:0] exp;
        int             cyc;
        exp         = ref_add(8'hA5, 8'h5A);
        bus.out_rdy = 1'b0;
        bus.in_a    = 8'hA5;
        bus.in_b    = 8'h5A;
        bus.in_val  = 1'b1;
        tick();
        bus.in_val = 1'b0;
        cyc = 1;
        while (bus.out_val !== 1'b1 && cyc < 64) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc !== 9) begin
            n_fail++; $display("FAIL bp_latency: got %0d want 9", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({bus.out_val, bus.in_rdy, bus.out_cout, bus.out_sum} !== {1'b1, 1'b0, exp}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got val=%b rdy=%b res=%h want val=1 rdy=0 res=%h",
                         i, bus.out_val, bus.in_rdy, {bus.out_cout, bus.out_sum}, exp);
            end
            tick();
        end
        n_checks++;
        if (bus.out_val !== 1'b1) begin
            n_fail++; $display("FAIL bp_still_valid: got %b want 1", bus.out_val);
        end
        bus.out_rdy = 1'b1;
        tick();
        n_checks++;
        if ({bus.in_rdy, bus.out_val} !== 2'b10) begin
            n_fail++; $display("FAIL bp_release: got rdy/val=%b want 10", {bus.in_rdy, bus.out_val});
        end
    endtask

    task automatic test_busy_ignored();
        int cyc;
        int extra;
        bus.in_a   = 8'h01;
        bus.in_b   = 8'h02;
        bus.in_val = 1'b1;
        tick();
        bus.in_val = 1'b0;
        tick();
        tick();
        bus.in_a   = 8'h33;
        bus.in_val = 1'b1;
        tick();
        bus.in_val = 1'b0;
        bus.in_a   = 8'h00;
        cyc = 4;
        while (bus.out_val !== 1'b1 && cyc < 64) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc !== 9) begin
            n_fail++; $display("FAIL busy_latency: got %0d want 9", cyc);
        end
        n_checks++;
        if ({bus.out_cout, bus.out_sum} !== ref_add(8'h01, 8'h02)) begin
            n_fail++; $display("FAIL busy_result: got %h want %h", {bus.out_cout, bus.out_sum},
                               ref_add(8'h01, 8'h02));
        end
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.out_val === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++; $display("FAIL busy_extra_result: got %0d valid cycles want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        logic [NBITS-1:0] sum;
        logic             cout;
        logic             rdy;
        int               cyc;
        int               seen;
        bus.in_a   = 8'hAA;
        bus.in_b   = 8'h55;
        bus.in_val = 1'b1;
        tick();
        bus.in_val = 1'b0;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.out_val, bus.in_rdy} !== 2'b00) begin
            n_fail++; $display("FAIL midreset_outputs: got val/rdy=%b want 00", {bus.out_val, bus.in_rdy});
        end
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL midreset_ready: got %b want 1", bus.in_rdy);
        end
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.out_val === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL midreset_ghost: got %0d valid cycles want 0", seen);
        end
        run_op(8'h10, 8'h20, sum, cout, cyc, rdy);
        n_checks++;
        if ({cout, sum, cyc} !== {ref_add(8'h10, 8'h20), 32'd9}) begin
            n_fail++; $display("FAIL midreset_recover: got res=%h cyc=%0d want res=%h cyc=9",
                               {cout, sum}, cyc, ref_add(8'h10, 8'h20));
        end
    endtask

    task automatic test_back_to_back();
        logic [NBITS:0] exp_q[$];
        logic [NBITS:0] exp;
        int             accepted;
        int             got;
        int             cyc;
        accepted = 0;
        got      = 0;
        cyc      = 0;
        while ((accepted < 200 || exp_q.size() > 0) && cyc < 20000) begin
            bus.in_val  = (accepted < 200);
            bus.in_a    = 8'($urandom);
            bus.in_b    = 8'($urandom);
            bus.out_rdy = 1'($urandom);
            if (bus.in_val && bus.in_rdy === 1'b1) begin
                exp_q.push_back(ref_add(bus.in_a, bus.in_b));
                accepted++;
            end
            if (bus.out_val === 1'b1 && bus.out_rdy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected: got res=%h want none",
                                       {bus.out_cout, bus.out_sum});
                end else begin
                    exp = exp_q.pop_front();
                    got++;
                    if ({bus.out_cout, bus.out_sum} !== exp) begin
                        n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h",
                                           got, {bus.out_cout, bus.out_sum}, exp);
                    end
                end
            end
            tick();
            cyc++;
        end
        bus.in_val  = 1'b0;
        bus.out_rdy = 1'b1;
        n_checks++;
        if (got !== 200) begin
            n_fail++; $display("FAIL b2b_count: got %0d results want 200", got);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL b2b_pending: got %0d outstanding want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_busy_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
